// File: rtl/dtw_result_collector_pkg.sv
// Shared definitions for the DTW result collector: FSM encoding, record word indices, record type.
// Default widths here are the parameter defaults of the collector and its interface.
// No logic; types and constants only.
package dtw_pkg;

  localparam int DTW_DWIDTH = 16;
  localparam int AXI_DWIDTH = 32;

  // Collector FSM: fetch one FIFO word, capture it, emit after the last word.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    CAPTURE = 2'd1,
    EMIT    = 2'd2
  } dtw_state_e;

  // Position of each word inside a serialised result record.
  localparam logic [1:0] WORD_QID    = 2'd0;
  localparam logic [1:0] WORD_POS    = 2'd1;
  localparam logic [1:0] WORD_MINVAL = 2'd2;
  localparam int         RES_WORDS   = 3;

  // One reassembled and classified result.
  typedef struct packed {
    logic [AXI_DWIDTH-1:0] qid;
    logic [AXI_DWIDTH-1:0] position;
    logic [DTW_DWIDTH-1:0] minval;
    logic                  hit;
  } dtw_result_t;

endpackage

// File: rtl/dtw_result_collector_if.sv
// Bundle between the collector and its neighbours: result-FIFO read port plus the record output stream.
// master = collector side (drives rden and out_*), slave = FIFO/host side (drives empty, data, out_ready).
// Pure wiring, no latency; out_ready is the only backpressure signal.
interface dtw_result_collector_if
  import dtw_pkg::*;
#(
  parameter int dtw_dwidth = DTW_DWIDTH,
  parameter int axi_dwidth = AXI_DWIDTH
);
  logic                  res_fifo_rden;
  logic                  res_fifo_empty;
  logic [axi_dwidth-1:0] res_fifo_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [axi_dwidth-1:0] out_qid;
  logic [axi_dwidth-1:0] out_position;
  logic [dtw_dwidth-1:0] out_minval;
  logic                  out_hit;

  modport master (
    output res_fifo_rden,
    input  res_fifo_empty,
    input  res_fifo_data,
    output out_valid,
    output out_qid,
    output out_position,
    output out_minval,
    output out_hit,
    input  out_ready
  );

  modport slave (
    input  res_fifo_rden,
    output res_fifo_empty,
    output res_fifo_data,
    input  out_valid,
    input  out_qid,
    input  out_position,
    input  out_minval,
    input  out_hit,
    output out_ready
  );
endinterface

// File: rtl/dtw_sat_counter.sv
// Saturating up-counter with synchronous clear; used for hit/miss statistics.
// Ports: clk, rst (async active-high), en (count this cycle), clr (zero, wins over en), count.
// One-cycle latency from en/clr to count; holds at all-ones instead of wrapping.
module dtw_sat_counter #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [width-1:0] count
);
  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};
  localparam logic [width-1:0] MAX = {width{1'b1}};

  logic [width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != MAX)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/dtw_result_collector.sv
// Drains the DTW sink FIFO, rebuilds {qid, position, minval} records, flags minval <= threshold, emits on valid/ready.
// Ports: clk, rst (async active-high), res_if (FIFO read + record stream), threshold, clear, frame_err, hit_count, miss_count.
// Latency: 2 cycles per word, out_valid on the edge ending the third capture; no FIFO reads while a record waits on out_ready.
// Optional: DTW_RESULT_STATS_EN enables saturating hit/miss counters; otherwise they read 0.
module dtw_result_collector
  import dtw_pkg::*;
#(
  parameter int dtw_dwidth = DTW_DWIDTH,
  parameter int axi_dwidth = AXI_DWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  dtw_result_collector_if.master res_if,
  input  logic [dtw_dwidth-1:0] threshold,
  input  logic                  clear,
  output logic                  frame_err,
  output logic [axi_dwidth-1:0] hit_count,
  output logic [axi_dwidth-1:0] miss_count
);

  dtw_state_e            state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [axi_dwidth-1:0] qid_q, qid_d;
  logic [axi_dwidth-1:0] pos_q, pos_d;
  logic [dtw_dwidth-1:0] minval_q, minval_d;
  logic                  hit_q, hit_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rden;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next state. An empty FIFO simply parks the FSM in FETCH with idx untouched.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (!res_if.res_fifo_empty) state_d = CAPTURE;
      CAPTURE: state_d = (idx_q == WORD_MINVAL) ? EMIT : FETCH;
      EMIT:    if (res_if.out_ready) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Outputs and datapath next values.
  always_comb begin
    rden        = (state_q == FETCH) && !res_if.res_fifo_empty;
    idx_d       = idx_q;
    qid_d       = qid_q;
    pos_d       = pos_q;
    minval_d    = minval_q;
    hit_d       = hit_q;
    valid_d     = valid_q;
    frame_err_d = frame_err_q;

    if (state_q == CAPTURE) begin
      case (idx_q)
        WORD_QID: qid_d = res_if.res_fifo_data;
        WORD_POS: pos_d = res_if.res_fifo_data;
        default: begin
          // Upper bits of the minval word must be zero; anything else means the
          // stream is out of frame, but the truncated record is still delivered.
          minval_d = res_if.res_fifo_data[dtw_dwidth-1:0];
          hit_d    = (res_if.res_fifo_data[dtw_dwidth-1:0] <= threshold);
          valid_d  = 1'b1;
          if (|res_if.res_fifo_data[axi_dwidth-1:dtw_dwidth]) frame_err_d = 1'b1;
        end
      endcase
      idx_d = (idx_q == WORD_MINVAL) ? WORD_QID : idx_q + 2'd1;
    end

    if ((state_q == EMIT) && res_if.out_ready) valid_d = 1'b0;

    // clear beats a coincident frame error.
    if (clear) frame_err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= WORD_QID;
      qid_q       <= '0;
      pos_q       <= '0;
      minval_q    <= '0;
      hit_q       <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      qid_q       <= qid_d;
      pos_q       <= pos_d;
      minval_q    <= minval_d;
      hit_q       <= hit_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign res_if.res_fifo_rden = rden;
  assign res_if.out_valid     = valid_q;
  assign res_if.out_qid       = qid_q;
  assign res_if.out_position  = pos_q;
  assign res_if.out_minval    = minval_q;
  assign res_if.out_hit       = hit_q;
  assign frame_err            = frame_err_q;

`ifdef DTW_RESULT_STATS_EN
  logic accept;
  assign accept = valid_q && res_if.out_ready;

  dtw_sat_counter #(.width(axi_dwidth)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (accept && hit_q),
    .clr   (clear),
    .count (hit_count)
  );

  dtw_sat_counter #(.width(axi_dwidth)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (accept && !hit_q),
    .clr   (clear),
    .count (miss_count)
  );
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dtw_result_collector.sv
// Bench for dtw_result_collector: FIFO model feeding random and directed records, reference model per record.
// Checks reset state, latency, hit/miss, backpressure, starvation, frame errors, mid-record reset, statistics.
// Stimulus and sampling on the falling edge; the DUT registers on the rising edge.
module tb_dtw_result_collector;
  import dtw_pkg::*;

  localparam int DW = 16;
  localparam int AW = 32;
`ifdef DTW_RESULT_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] threshold;
  logic          clear;
  logic          frame_err;
  logic [AW-1:0] hit_count;
  logic [AW-1:0] miss_count;

  always #5 clk = ~clk;

  dtw_result_collector_if #(.dtw_dwidth(DW), .axi_dwidth(AW)) bus ();

  dtw_result_collector dut (
    .clk        (clk),
    .rst        (rst),
    .res_if     (bus),
    .threshold  (threshold),
    .clear      (clear),
    .frame_err  (frame_err),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  // Result FIFO model: data appears the cycle after a read strobe.
  logic [AW-1:0] fifo_mem [0:255];
  logic [31:0]   wr_ptr = '0;
  logic [31:0]   rd_ptr = '0;

  assign bus.res_fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.res_fifo_rden && (wr_ptr != rd_ptr)) begin
      bus.res_fifo_data <= fifo_mem[rd_ptr[7:0]];
      rd_ptr            <= rd_ptr + 32'd1;
    end
  end

  int          tests_run = 0;
  int          failures  = 0;
  logic [AW-1:0] exp_hits   = '0;
  logic [AW-1:0] exp_misses = '0;
  logic          exp_ferr   = 1'b0;

  // Reference: a record is the three words, minval truncated to DW bits, hit when minval <= threshold.
  function automatic dtw_result_t model(input logic [AW-1:0] w0, input logic [AW-1:0] w1,
                                        input logic [AW-1:0] w2, input logic [DW-1:0] thr);
    dtw_result_t r;
    r.qid      = w0;
    r.position = w1;
    r.minval   = w2[DW-1:0];
    r.hit      = (int'(w2[DW-1:0]) <= int'(thr));
    return r;
  endfunction

  function automatic dtw_result_t obs();
    dtw_result_t r;
    r.qid      = bus.out_qid;
    r.position = bus.out_position;
    r.minval   = bus.out_minval;
    r.hit      = bus.out_hit;
    return r;
  endfunction

  task automatic push_word(input logic [AW-1:0] w);
    fifo_mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 32'd1;
  endtask

  task automatic push_record(input logic [AW-1:0] w0, input logic [AW-1:0] w1, input logic [AW-1:0] w2);
    push_word(w0);
    push_word(w1);
    push_word(w2);
    if (w2[AW-1:DW] != '0) exp_ferr = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic note_accept(input logic hit);
    if (hit) begin
      if (exp_hits != '1) exp_hits = exp_hits + 1'b1;
    end else begin
      if (exp_misses != '1) exp_misses = exp_misses + 1'b1;
    end
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_hits   = '0;
    exp_misses = '0;
    exp_ferr   = 1'b0;
  endtask

  task automatic test_reset();
    dtw_result_t zero;
    zero = '0;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b expected 0", bus.out_valid); end
    tests_run++; if (obs() !== zero) begin failures++; $display("FAIL reset_fields got %h expected %h", obs(), zero); end
    tests_run++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got %b expected 0", frame_err); end
    tests_run++; if (hit_count !== '0) begin failures++; $display("FAIL reset_hit_count got %h expected 0", hit_count); end
    tests_run++; if (miss_count !== '0) begin failures++; $display("FAIL reset_miss_count got %h expected 0", miss_count); end
    tests_run++; if (bus.res_fifo_rden !== 1'b0) begin failures++; $display("FAIL reset_rden got %b expected 0", bus.res_fifo_rden); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    dtw_result_t e;
    int cyc;
    bit ok;
    threshold = 16'h0060;
    e = model(32'h7, 32'h1F4, 32'h0000_0050, threshold);
    push_record(32'h7, 32'h1F4, 32'h0000_0050);
    wait_valid(100, cyc, ok);
    tests_run++; if (!ok) begin failures++; $display("FAIL basic_timeout no out_valid within %0d cycles", cyc); end
    tests_run++; if (cyc != 6) begin failures++; $display("FAIL basic_latency got %0d cycles expected 6", cyc); end
    tests_run++; if (obs() !== e) begin failures++; $display("FAIL basic_record got %h expected %h", obs(), e); end
    tests_run++; if (frame_err !== 1'b0) begin failures++; $display("FAIL basic_frame_err got %b expected 0", frame_err); end
    note_accept(e.hit);
    @(negedge clk);
    tests_run++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_drop_valid got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_miss_backpressure();
    dtw_result_t e, eb;
    logic [AW-1:0] b0, b1, b2;
    int cyc;
    bit ok;
    threshold     = 16'h0060;
    bus.out_ready = 1'b0;
    e  = model(32'h8, 32'h10, 32'h0000_0090, threshold);
    b0 = $urandom; b1 = $urandom; b2 = {16'h0, 16'($urandom)};
    eb = model(b0, b1, b2, threshold);
    push_record(32'h8, 32'h10, 32'h0000_0090);
    push_record(b0, b1, b2);  // keeps the FIFO non-empty during the stall
    wait_valid(100, cyc, ok);
    tests_run++; if (!ok) begin failures++; $display("FAIL bp_timeout no out_valid within %0d cycles", cyc); end
    tests_run++; if (obs() !== e) begin failures++; $display("FAIL bp_record got %h expected %h", obs(), e); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got %b expected 1", i, bus.out_valid); end
      tests_run++; if (obs() !== e) begin failures++; $display("FAIL bp_stable[%0d] got %h expected %h", i, obs(), e); end
      tests_run++; if (bus.res_fifo_rden !== 1'b0) begin failures++; $display("FAIL bp_no_rden[%0d] got %b expected 0", i, bus.res_fifo_rden); end
    end
    bus.out_ready = 1'b1;
    note_accept(e.hit);
    @(negedge clk);
    tests_run++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_accept got %b expected 0", bus.out_valid); end
    wait_valid(100, cyc, ok);
    tests_run++; if (!ok || obs() !== eb) begin failures++; $display("FAIL bp_next_record got %h expected %h", obs(), eb); end
    note_accept(eb.hit);
    @(negedge clk);
  endtask

  task automatic test_starved();
    dtw_result_t e;
    logic [AW-1:0] w0, w1, w2;
    int cyc;
    bit ok;
    threshold = 16'($urandom);
    w0 = $urandom; w1 = $urandom; w2 = {16'h0, 16'($urandom)};
    e  = model(w0, w1, w2, threshold);
    push_word(w0);
    push_word(w1);
    repeat (20) @(negedge clk);
    tests_run++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL starved_valid got %b expected 0", bus.out_valid); end
    tests_run++; if (bus.res_fifo_rden !== 1'b0) begin failures++; $display("FAIL starved_rden got %b expected 0", bus.res_fifo_rden); end
    push_word(w2);
    wait_valid(100, cyc, ok);
    tests_run++; if (!ok) begin failures++; $display("FAIL starved_timeout no out_valid within %0d cycles", cyc); end
    tests_run++; if (obs() !== e) begin failures++; $display("FAIL starved_record got %h expected %h", obs(), e); end
    note_accept(e.hit);
    @(negedge clk);
  endtask

  task automatic test_frame_err();
    dtw_result_t e, eb;
    logic [AW-1:0] a0, a1, b0, b1, b2;
    int cyc;
    bit ok;
    threshold = 16'h0060;
    a0 = $urandom; a1 = $urandom;
    e  = model(a0, a1, 32'h0001_0020, threshold);
    push_record(a0, a1, 32'h0001_0020);
    wait_valid(100, cyc, ok);
    tests_run++; if (!ok || obs() !== e) begin failures++; $display("FAIL ferr_record got %h expected %h", obs(), e); end
    tests_run++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set got %b expected 1", frame_err); end
    note_accept(e.hit);
    b0 = $urandom; b1 = $urandom; b2 = {16'h0, 16'($urandom)};
    eb = model(b0, b1, b2, threshold);
    push_record(b0, b1, b2);
    wait_valid(100, cyc, ok);
    tests_run++; if (!ok || obs() !== eb) begin failures++; $display("FAIL ferr_clean_record got %h expected %h", obs(), eb); end
    tests_run++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_sticky got %b expected 1", frame_err); end
    note_accept(eb.hit);
    clear_pulse();
    tests_run++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear got %b expected 0", frame_err); end
    tests_run++; if (bus.out_qid !== b0) begin failures++; $display("FAIL ferr_clear_keeps_qid got %h expected %h", bus.out_qid, b0); end
    tests_run++; if (hit_count !== '0 || miss_count !== '0) begin failures++; $display("FAIL ferr_clear_counters got %h/%h expected 0/0", hit_count, miss_count); end
  endtask

  task automatic test_reset_mid();
    dtw_result_t e, zero;
    logic [AW-1:0] w0, w1, w2;
    int cyc;
    bit ok;
    zero = '0;
    push_word($urandom);
    push_word($urandom);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got %b expected 0", bus.out_valid); end
    tests_run++; if (obs() !== zero) begin failures++; $display("FAIL rstmid_fields got %h expected %h", obs(), zero); end
    rst = 1'b0;
    exp_hits = '0; exp_misses = '0; exp_ferr = 1'b0;
    threshold = 16'($urandom);
    w0 = $urandom; w1 = $urandom; w2 = {16'h0, 16'($urandom)};
    e  = model(w0, w1, w2, threshold);
    push_record(w0, w1, w2);
    wait_valid(100, cyc, ok);
    tests_run++; if (!ok || obs() !== e) begin failures++; $display("FAIL rstmid_record got %h expected %h", obs(), e); end
    note_accept(e.hit);
    @(negedge clk);
  endtask

  task automatic test_random();
    dtw_result_t e;
    logic [AW-1:0] w0, w1, w2;
    int cyc, stall;
    bit ok;
    clear_pulse();
    for (int n = 0; n < 24; n++) begin
      bus.out_ready = 1'b0;
      threshold = 16'($urandom);
      w0 = $urandom; w1 = $urandom;
      w2 = {(($urandom_range(0, 7) == 0) ? 16'($urandom | 1) : 16'h0), 16'($urandom)};
      e  = model(w0, w1, w2, threshold);
      push_record(w0, w1, w2);
      wait_valid(100, cyc, ok);
      tests_run++; if (!ok || obs() !== e) begin failures++; $display("FAIL rand_record[%0d] got %h expected %h", n, obs(), e); end
      tests_run++; if (frame_err !== exp_ferr) begin failures++; $display("FAIL rand_frame_err[%0d] got %b expected %b", n, frame_err, exp_ferr); end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        tests_run++; if (bus.out_valid !== 1'b1 || obs() !== e) begin failures++; $display("FAIL rand_hold[%0d] got %b/%h expected 1/%h", n, bus.out_valid, obs(), e); end
      end
      bus.out_ready = 1'b1;
      note_accept(e.hit);
      @(negedge clk);
      tests_run++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rand_accept[%0d] got %b expected 0", n, bus.out_valid); end
    end
    tests_run++; if (hit_count !== (STATS_EN ? exp_hits : '0)) begin failures++; $display("FAIL rand_hit_count got %h expected %h", hit_count, STATS_EN ? exp_hits : '0); end
    tests_run++; if (miss_count !== (STATS_EN ? exp_misses : '0)) begin failures++; $display("FAIL rand_miss_count got %h expected %h", miss_count, STATS_EN ? exp_misses : '0); end
  endtask

  task automatic test_stats();
    logic [DW-1:0] mv [5];
    int cyc;
    bit ok;
    mv = '{16'h0010, 16'h0200, 16'h0020, 16'h0300, 16'h0030};
    clear_pulse();
    bus.out_ready = 1'b1;
    threshold     = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      push_record($urandom, $urandom, {16'h0, mv[i]});
      wait_valid(100, cyc, ok);
      tests_run++; if (!ok) begin failures++; $display("FAIL stats_timeout[%0d] no out_valid within %0d cycles", i, cyc); end
      note_accept(mv[i] <= threshold);
    end
    @(negedge clk);
    tests_run++; if (hit_count !== (STATS_EN ? 32'd3 : 32'd0)) begin failures++; $display("FAIL stats_hits got %0d expected %0d", hit_count, STATS_EN ? 3 : 0); end
    tests_run++; if (miss_count !== (STATS_EN ? 32'd2 : 32'd0)) begin failures++; $display("FAIL stats_misses got %0d expected %0d", miss_count, STATS_EN ? 2 : 0); end
`ifdef DTW_RESULT_STATS_EN
    force dut.u_hit_cnt.count_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.u_hit_cnt.count_q;
    for (int i = 0; i < 2; i++) begin
      push_record($urandom, $urandom, 32'h0000_0001);
      wait_valid(100, cyc, ok);
      @(negedge clk);
      tests_run++; if (hit_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL stats_saturate[%0d] got %h expected ffffffff", i, hit_count); end
    end
    tests_run++; if (miss_count !== 32'd2) begin failures++; $display("FAIL stats_miss_untouched got %0d expected 2", miss_count); end
`endif
  endtask

  initial begin
    rst           = 1'b1;
    clear         = 1'b0;
    threshold     = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_miss_backpressure();
    test_starved();
    test_frame_err();
    test_reset_mid();
    test_random();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, %0d tests run", tests_run);
    $fatal(1);
  end

endmodule
